mem_arb_rr: RTL and testbench

Parametrised N-channel round-robin arbiter between the L1 caches (I-cache, D-cache, and later page-walker or DMA masters) and main memory. Each requester issues one line-sized read or write and holds its request until a one-cycle done pulse. The arbiter serialises transactions onto a single fixed-latency memory port. It also drives per-channel stall lines consumed by pipeline stall control.

---
 rtl/mem_arb_rr_pkg.sv | 16 +
 rtl/rr_pick.sv | 30 +++
 rtl/mem_arb_rr.sv | 149 ++++++++++++++
 tb/tb_mem_arb_rr.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_rr_pkg.sv
// Shared types for the round-robin memory arbiter.
// FSM state encoding and an index-width helper.
package mem_arb_rr_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  // Width of an index/counter covering 0..n-1, never below one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
// Ports: cand (candidate mask), last (previous winner), win (one-hot).
module rr_pick
  import mem_arb_rr_pkg::*;
#(
  parameter  int N  = 2,
  localparam int IW = idx_w(N)
) (
  input  logic [N-1:0]  cand,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  win
);

  // Scan last+1, last+2, ... (mod N); first candidate wins.
  always_comb begin
    logic found;
    win   = '0;
    found = 1'b0;
    for (int k = 1; k <= N; k++) begin
      for (int i = 0; i < N; i++) begin
        if (!found && cand[i] &&
            ((int'(last) + k) % N == i)) begin
          win[i] = 1'b1;
          found  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/mem_arb_rr.sv
// N-channel round-robin arbiter onto a fixed-latency memory port.
// Ports: clock/rst, per-channel req/req_we/req_addr/req_wdata,
// grant/done/stall per channel, rdata, and the mem_* port.
module mem_arb_rr
  import mem_arb_rr_pkg::*;
#(
  parameter int NUM_CH      = 2,
  parameter int ADDR_W      = 20,
  parameter int LINE_W      = 128,
  parameter int MEM_LATENCY = 5,
  parameter bit WRITE_FIRST = 1'b1
) (
  input  logic                     clock,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        req,
  input  logic [NUM_CH-1:0]        req_we,
  input  logic [NUM_CH*ADDR_W-1:0] req_addr,
  input  logic [NUM_CH*LINE_W-1:0] req_wdata,
  output logic [NUM_CH-1:0]        grant,
  output logic [NUM_CH-1:0]        done,
  output logic [LINE_W-1:0]        rdata,
  output logic [NUM_CH-1:0]        stall,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [LINE_W-1:0]        mem_wdata,
  input  logic [LINE_W-1:0]        mem_rdata
);

  localparam int IW = idx_w(NUM_CH);
  localparam int CW = idx_w(MEM_LATENCY);

  localparam logic [CW-1:0] CNT_LOAD =
    CW'(MEM_LATENCY - 1);
  localparam logic [IW-1:0] LAST_RST =
    IW'(NUM_CH - 1);

  state_t state;
  state_t state_nx;

  logic [CW-1:0]     cnt;
  logic [IW-1:0]     last;
  logic [IW-1:0]     ch;
  logic [NUM_CH-1:0] cand;
  logic [NUM_CH-1:0] win;
  logic [IW-1:0]     win_idx;
  logic              win_we;
  logic [ADDR_W-1:0] win_addr;
  logic [LINE_W-1:0] win_wdata;

  // Pending writes shadow pending reads when enabled.
  always_comb begin
    cand = req;
    if (WRITE_FIRST && |(req & req_we))
      cand = req & req_we;
  end

  rr_pick #(
    .N (NUM_CH)
  ) u_pick (
    .cand (cand),
    .last (last),
    .win  (win)
  );

  always_comb begin
    win_idx   = '0;
    win_we    = 1'b0;
    win_addr  = '0;
    win_wdata = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (win[i]) begin
        win_idx   = IW'(i);
        win_we    = req_we[i];
        win_addr  = req_addr[i*ADDR_W +: ADDR_W];
        win_wdata = req_wdata[i*LINE_W +: LINE_W];
      end
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:
        if (|req) state_nx = S_ACCESS;
      S_ACCESS:
        if (cnt == '0) state_nx = S_RESP;
      S_RESP:
        state_nx = S_IDLE;
      default:
        state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // mem_we doubles as the latched direction of the
  // transaction until the last access cycle.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      grant     <= '0;
      done      <= '0;
      rdata     <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cnt       <= '0;
      last      <= LAST_RST;
      ch        <= '0;
    end else begin
      done <= '0;
      unique case (state)
        S_IDLE: begin
          if (|req) begin
            ch        <= win_idx;
            grant     <= win;
            mem_req   <= 1'b1;
            mem_we    <= win_we;
            mem_addr  <= win_addr;
            mem_wdata <= win_wdata;
            cnt       <= CNT_LOAD;
          end
        end
        S_ACCESS: begin
          if (cnt == '0) begin
            if (!mem_we) rdata <= mem_rdata;
            done    <= grant;
            grant   <= '0;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        S_RESP: begin
          last <= ch;
        end
        default: ;
      endcase
    end
  end

  assign stall = req & ~done;

endmodule

// File: tb/tb_mem_arb_rr.sv
// Self-checking bench for mem_arb_rr (4 channels, latency 5).
// Timeline model plus directed scenarios with literal checks.
module tb_mem_arb_rr;

  localparam int N  = 4;
  localparam int AW = 20;
  localparam int LW = 128;
  localparam int L  = 5;
  localparam bit WF = 1'b1;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [LW-1:0] wdata;
  } txn_t;

  logic            clock = 1'b0;
  logic            rst;
  logic [N-1:0]    req, req_we;
  logic [N*AW-1:0] req_addr;
  logic [N*LW-1:0] req_wdata;
  logic [N-1:0]    grant, done, stall;
  logic [LW-1:0]   rdata, mem_wdata, mem_rdata;
  logic            mem_req, mem_we;
  logic [AW-1:0]   mem_addr;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  txn_t         q [N][$];
  logic [N-1:0] drop = '0;
  logic [N-1:0] seen_done = '0;

  int            m_owner = -1;
  int            m_start = 0;
  int            m_last  = N - 1;
  logic          m_we    = 1'b0;
  logic [AW-1:0] m_addr  = '0;
  logic [LW-1:0] m_wdata = '0;
  logic [LW-1:0] m_rdata = '0;

  int   gorder[$];
  int   gcyc[$];
  int   dlog[$];
  int   dcyc[$];
  logic welog[$];
  logic [N-1:0] prev_g = '0;

  mem_arb_rr #(
    .NUM_CH      (N),
    .ADDR_W      (AW),
    .LINE_W      (LW),
    .MEM_LATENCY (L),
    .WRITE_FIRST (WF)
  ) dut (
    .clock     (clock),
    .rst       (rst),
    .req       (req),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .grant     (grant),
    .done      (done),
    .rdata     (rdata),
    .stall     (stall),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  initial begin
    #1000000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1);
  end

  task automatic chk(input string nm,
                     input logic [LW-1:0] act,
                     input logic [LW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d got=%h want=%h",
               nm, cyc, act, exp);
    end
  endtask

  function automatic logic [LW-1:0] mk_rd(input int c);
    return {32'(32'h0BAD0000 ^ c), 32'(32'hCAFE0000 + c),
            32'(~c), 32'(c * 7)};
  endfunction

  task automatic push(input int ch, input logic we,
                      input logic [AW-1:0] a,
                      input logic [LW-1:0] d);
    txn_t x;
    x.we = we;
    x.addr = a;
    x.wdata = d;
    q[ch].push_back(x);
  endtask

  function automatic bit qempty();
    for (int i = 0; i < N; i++)
      if (q[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic clear_logs();
    gorder.delete();
    gcyc.delete();
    dlog.delete();
    dcyc.delete();
    welog.delete();
  endtask

  // Requesters: pop on the edge after their done pulse.
  task automatic cyc_step();
    @(posedge clock);
    #1;
    mem_rdata = mk_rd(cyc);
    for (int i = 0; i < N; i++) begin
      if (seen_done[i] && q[i].size() > 0) begin
        void'(q[i].pop_front());
        drop[i] = 1'b0;
      end
      req[i] = (q[i].size() > 0) && !drop[i];
      if (q[i].size() > 0) begin
        req_we[i] = q[i][0].we;
        req_addr[i*AW +: AW] = q[i][0].addr;
        req_wdata[i*LW +: LW] = q[i][0].wdata;
      end else begin
        req_we[i] = 1'b0;
        req_addr[i*AW +: AW] = '0;
        req_wdata[i*LW +: LW] = '0;
      end
    end
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 300 && !ok; n++) begin
      cyc_step();
      ok = qempty() && (m_owner < 0);
    end
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL wait_idle cyc=%0d got=busy want=idle",
               cyc);
    end
    cyc_step();
    cyc_step();
  endtask

  // Timeline model: a transaction that wins arbitration in
  // cycle s owns cycles s+1..s+L and pulses done in s+L+1.
  always @(negedge clock) begin
    logic [N-1:0] eg, ed, cand, tmp;
    logic         emr;
    int           k, pick;
    eg = '0;
    ed = '0;
    emr = 1'b0;
    k = 0;
    if (rst) begin
      m_owner = -1;
      m_last = N - 1;
      m_rdata = '0;
    end else if (m_owner >= 0) begin
      k = cyc - m_start;
      if (k >= 1 && k <= L) begin
        eg = N'(1) << m_owner;
        emr = 1'b1;
      end else if (k == L + 1) begin
        ed = N'(1) << m_owner;
      end
    end
    chk("grant", grant, eg);
    chk("done", done, ed);
    chk("mem_req", mem_req, emr);
    chk("rdata", rdata, m_rdata);
    chk("stall", stall, req & ~ed);
    chk("grant_onehot", $onehot0(grant), 1'b1);
    if (emr) begin
      chk("mem_we", mem_we, m_we);
      chk("mem_addr", mem_addr, m_addr);
      chk("mem_wdata", mem_wdata, m_wdata);
    end else if (rst) begin
      chk("rst_mem_we", mem_we, 1'b0);
      chk("rst_mem_addr", mem_addr, '0);
      chk("rst_mem_wdata", mem_wdata, '0);
    end else begin
      chk("idle_mem_we", mem_we, 1'b0);
    end
    if (!rst) begin
      if (m_owner >= 0) begin
        if (k == L && !m_we) m_rdata = mem_rdata;
        if (k == L + 1) begin
          m_last = m_owner;
          m_owner = -1;
        end
      end else if (req != '0) begin
        cand = req;
        if (WF && (req & req_we) != '0)
          cand = req & req_we;
        pick = -1;
        for (int s = 1; s <= N; s++) begin
          tmp = cand >> ((m_last + s) % N);
          if (pick < 0 && tmp[0])
            pick = (m_last + s) % N;
        end
        m_owner = pick;
        m_start = cyc;
        tmp = req_we >> pick;
        m_we = tmp[0];
        m_addr = AW'(req_addr >> (pick * AW));
        m_wdata = LW'(req_wdata >> (pick * LW));
      end
    end
    if (grant != '0 && prev_g == '0) begin
      for (int i = 0; i < N; i++)
        if (grant[i]) gorder.push_back(i);
      gcyc.push_back(cyc);
      welog.push_back(mem_we);
    end
    prev_g = grant;
    if (done != '0) begin
      for (int i = 0; i < N; i++)
        if (done[i]) dlog.push_back(i);
      dcyc.push_back(cyc);
    end
    seen_done = done;
  end

  initial begin
    int t, rf;
    int exp_rr[6];
    int exp_sc[5];
    exp_rr = '{1, 0, 1, 0, 1, 0};
    exp_sc = '{0, 1, 2, 3, 0};
    rst = 1'b1;
    req = '0;
    req_we = '0;
    req_addr = '0;
    req_wdata = '0;
    mem_rdata = '0;
    cyc_step();
    cyc_step();
    @(negedge clock);
    chk("rst_grant", grant, '0);
    chk("rst_done", done, '0);
    chk("rst_rdata", rdata, '0);
    chk("rst_mem_req", mem_req, 1'b0);
    cyc_step();
    rst = 1'b0;
    cyc_step();
    cyc_step();

    // single read on ch0
    push(0, 1'b0, 20'h00040, '0);
    cyc_step();
    t = cyc;
    @(negedge clock);
    chk("rd_stall_t0", stall[0], 1'b1);
    chk("rd_grant_t0", grant, '0);
    cyc_step();
    @(negedge clock);
    chk("rd_grant_t1", grant, 4'b0001);
    chk("rd_mem_req_t1", mem_req, 1'b1);
    cyc_step();
    cyc_step();
    @(negedge clock);
    chk("rd_addr_t3", mem_addr, 20'h00040);
    cyc_step();
    cyc_step();
    @(negedge clock);
    chk("rd_grant_t5", grant, 4'b0001);
    chk("rd_stall_t5", stall[0], 1'b1);
    cyc_step();
    @(negedge clock);
    chk("rd_done_t6", done, 4'b0001);
    chk("rd_grant_t6", grant, '0);
    chk("rd_stall_t6", stall[0], 1'b0);
    chk("rd_rdata_t6", rdata, mk_rd(t + 5));
    wait_idle();

    // round-robin between two readers, last=0
    clear_logs();
    for (int k = 0; k < 3; k++) begin
      push(0, 1'b0, 20'h00100 + 20'(k), '0);
      push(1, 1'b0, 20'h00200 + 20'(k), '0);
    end
    wait_idle();
    chk("rr_count", gorder.size(), 6);
    if (gorder.size() == 6)
      for (int k = 0; k < 6; k++)
        chk($sformatf("rr_order%0d", k), gorder[k],
            exp_rr[k]);
    if (dcyc.size() == 6) begin
      chk("rr_space01", dcyc[1] - dcyc[0], 7);
      chk("rr_space45", dcyc[5] - dcyc[4], 7);
    end

    // write priority with last=1
    push(1, 1'b0, 20'h00300, '0);
    wait_idle();
    clear_logs();
    push(0, 1'b0, 20'h00400, '0);
    push(1, 1'b1, 20'h00500, {4{32'hDEADBEEF}});
    wait_idle();
    chk("wf_count", gorder.size(), 2);
    if (gorder.size() == 2) begin
      chk("wf_first", gorder[0], 1);
      chk("wf_second", gorder[1], 0);
      chk("wf_we_first", welog[0], 1'b1);
      chk("wf_we_second", welog[1], 1'b0);
    end

    // request arriving during another's access
    clear_logs();
    push(0, 1'b0, 20'h00600, '0);
    cyc_step();
    cyc_step();
    cyc_step();
    push(1, 1'b0, 20'h00700, '0);
    wait_idle();
    chk("held_count", gorder.size(), 2);
    if (gcyc.size() == 2) begin
      chk("held_order", gorder[1], 1);
      chk("held_gap", gcyc[1] - gcyc[0], 7);
    end

    // requester drops req mid-transaction
    clear_logs();
    push(2, 1'b0, 20'h00800, '0);
    cyc_step();
    cyc_step();
    cyc_step();
    drop[2] = 1'b1;
    cyc_step();
    @(negedge clock);
    chk("drop_stall", stall[2], 1'b0);
    chk("drop_grant", grant, 4'b0100);
    wait_idle();
    chk("drop_dones", dlog.size(), 1);
    if (dlog.size() == 1) chk("drop_done_ch", dlog[0], 2);

    // reset during access
    clear_logs();
    push(3, 1'b0, 20'h00900, '0);
    cyc_step();
    cyc_step();
    cyc_step();
    cyc_step();
    #2;
    rst = 1'b1;
    #1;
    chk("arst_grant", grant, '0);
    chk("arst_mem_req", mem_req, 1'b0);
    chk("arst_mem_addr", mem_addr, '0);
    cyc_step();
    cyc_step();
    rst = 1'b0;
    rf = cyc;
    cyc_step();
    @(negedge clock);
    chk("arst_regrant_cyc", cyc - rf, 1);
    chk("arst_regrant", grant, 4'b1000);
    wait_idle();
    chk("arst_dones", dlog.size(), 1);

    // four readers at once, last=3
    clear_logs();
    push(0, 1'b0, 20'h00A00, '0);
    push(0, 1'b0, 20'h00A04, '0);
    push(1, 1'b0, 20'h00A10, '0);
    push(2, 1'b0, 20'h00A20, '0);
    push(3, 1'b0, 20'h00A30, '0);
    wait_idle();
    chk("scale_count", gorder.size(), 5);
    chk("scale_dones", dlog.size(), 5);
    if (gorder.size() == 5)
      for (int k = 0; k < 5; k++)
        chk($sformatf("scale_order%0d", k), gorder[k],
            exp_sc[k]);

    // writes first among four channels, last=0
    clear_logs();
    push(1, 1'b0, 20'h00B10, '0);
    push(2, 1'b1, 20'h00B20, {4{32'h12345678}});
    push(3, 1'b1, 20'h00B30, {4{32'h9ABCDEF0}});
    wait_idle();
    chk("mix_count", gorder.size(), 3);
    if (gorder.size() == 3) begin
      chk("mix_first", gorder[0], 2);
      chk("mix_second", gorder[1], 3);
      chk("mix_third", gorder[2], 1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
